// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M/RV64M multiply/divide unit with valid/ready handshake and flush
module execute_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int N = XLEN / UNROLL;
    localparam int CW = $clog2(N);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state;
    logic [2:0] op_q;
    logic [XLEN-1:0] a_mag, b_mag, a_abs, b_abs, quo_s, rem_s, res_nx;
    logic sign_a, sign_b, sa, sb, div_zero, div_ovf;
    logic [2*XLEN-1:0] prod, prod_nx, prod_s, p;
    logic [XLEN:0] t;
    logic [CW-1:0] cnt;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    always_comb begin
        sa = src_a[XLEN-1] & (op == 3'd1 | op == 3'd2 | op == 3'd4 | op == 3'd6);
        sb = src_b[XLEN-1] & (op == 3'd1 | op == 3'd4 | op == 3'd6);
        a_abs = sa ? -src_a : src_a;
        b_abs = sb ? -src_b : src_b;
        div_zero = op[2] & (src_b == '0);
        div_ovf = op[2] & !op[0] & (src_a == MIN_INT) & (src_b == '1);
    end
    // prod holds {hi, lo}: mul keeps {partial product, multiplier}, div keeps {remainder, dividend/quotient}
    always_comb begin
        p = prod;
        t = '0;
        for (int k = 0; k < UNROLL; k++) begin
            if (op_q[2]) begin
                t = {p[2*XLEN-1:XLEN], p[XLEN-1]};
                p = p << 1;
                if (t >= {1'b0, b_mag}) begin
                    t = t - {1'b0, b_mag};
                    p[0] = 1'b1;
                end
                p[2*XLEN-1:XLEN] = t[XLEN-1:0];
            end else begin
                t = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, a_mag} : '0);
                p = {t, p[XLEN-1:1]};
            end
        end
        prod_nx = p;
    end
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -prod : prod;
        quo_s = (sign_a ^ sign_b) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_s = sign_a ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        res_nx = op_q[2] ? (op_q[1] ? rem_s : quo_s)
               : (op_q == 3'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q <= '0;
            a_mag <= '0;
            b_mag <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            prod <= '0;
            cnt <= '0;
            result <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            out_valid <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= op;
                    a_mag <= a_abs;
                    b_mag <= b_abs;
                    // special divides preload the final {rem, quo} with no sign fixup
                    if (div_zero || div_ovf) begin
                        sign_a <= 1'b0;
                        sign_b <= 1'b0;
                        prod <= div_zero ? {src_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_INT};
                        state <= FIXUP;
                    end else begin
                        sign_a <= sa;
                        sign_b <= sb;
                        prod <= {{XLEN{1'b0}}, op[2] ? a_abs : b_abs};
                        state <= CALC;
                    end
                end
                CALC: begin
                    prod <= prod_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cnt <= '0;
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    result <= res_nx;
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
